// File: rtl/alu_mem_pkg.sv
// Shared types for the ALU -> memory datapath: word width, the load/store FSM
// states, the response record and the address legality check.
package alu_mem_pkg;

  localparam int WORD_W = 32;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } mem_state_t;

  typedef struct packed {
    logic [WORD_W-1:0] rdata;
    logic              err;
  } mem_rsp_t;

  // A byte address is legal only if word aligned and inside the array; the
  // full upper field is compared so high bits can never alias into it.
  function automatic logic addr_err(input logic [WORD_W-1:0] addr,
                                    input int unsigned       depth);
    return (addr[1:0] != 2'b00) || ({2'b00, addr[WORD_W-1:2]} >= depth);
  endfunction

endpackage

// File: rtl/data_mem_stage_mem_array.sv
// Single-port synchronous RAM with registered read (one-cycle latency).
module mem_array
  import alu_mem_pkg::*;
#(
  parameter  int unsigned DEPTH = 256,
  localparam int          AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     addr,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] mem [DEPTH];

  // NOTE: the storage array has no reset; clearing it would force flops
  // instead of a RAM macro, and its contents are undefined until written.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/data_mem_stage.sv
// Load/store stage: serialises one word access at a time into mem_array and
// returns load data or a write acknowledge on a valid/ready response channel.
module data_mem_stage
  import alu_mem_pkg::*;
#(
  parameter int unsigned DEPTH = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [WORD_W-1:0] req_addr,
  input  logic [WORD_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [WORD_W-1:0] rsp_rdata,
  output logic              rsp_err
);

  localparam int AW = $clog2(DEPTH);

  mem_state_t        state, state_nxt;
  logic              we_q;
  logic [WORD_W-1:0] addr_q;
  logic [WORD_W-1:0] wdata_q;
  mem_rsp_t          rsp_q;

  logic              accept;
  logic              err;
  logic              ram_we;
  logic [AW-1:0]     ram_addr;
  logic [WORD_W-1:0] ram_rdata;

  assign accept = req_valid && req_ready;
  assign err    = addr_err(addr_q, DEPTH);

  // The RAM read is launched on the accept edge from the live address, so the
  // data is ready during ACCESS; afterwards the latched address drives it.
  assign ram_addr = (state == IDLE) ? req_addr[AW+1:2] : addr_q[AW+1:2];

  // NOTE: every signal written here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_nxt = state;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    ram_we    = 1'b0;
    unique case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_nxt = ACCESS;
      end
      ACCESS: begin
        ram_we    = we_q && !err;
        state_nxt = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // its inputs from before the edge, independent of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (accept) begin
      we_q    <= req_we;
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
    end
  end

  // Response is captured on the edge leaving ACCESS and held through RESP.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_q <= '0;
    end else if (state == ACCESS) begin
      rsp_q.rdata <= (we_q || err) ? '0 : ram_rdata;
      rsp_q.err   <= err;
    end
  end

  assign rsp_rdata = rsp_q.rdata;
  assign rsp_err   = rsp_q.err;

  mem_array #(.DEPTH(DEPTH)) u_mem_array (
    .clk   (clk),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (wdata_q),
    .rdata (ram_rdata)
  );

endmodule
